// File: rtl/stage_read_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_read_regs_if
// Description : Writeback port into the operand-read stage register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_read_regs_if;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    modport master (
        output ctrl_writeEnable,
        output ctrl_writeReg,
        output data_writeReg
    );

    modport slave (
        input  ctrl_writeEnable,
        input  ctrl_writeReg,
        input  data_writeReg
    );
endinterface
`default_nettype wire

// File: rtl/stage_read_regs.sv
`default_nettype none
// ============================================================================
// Module      : stage_read_regs
// Description : Operand-read stage with register file, write-through bypass,
//               load-use hazard detection and the D/X pipeline latch.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_read_regs #(
    parameter int          NREGS   = 32,
    parameter logic [4:0]  RSTATUS = 5'd30,
    parameter logic [31:0] NOP     = 32'd0
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic [31:0] insn_in,
    input  wire logic [31:0] pc_in,
    input  wire logic        flush,
    stage_read_regs_if.slave wb,
    output logic             stall_out,
    output logic [31:0]      dx_insn,
    output logic [31:0]      dx_pc,
    output logic [31:0]      dx_a,
    output logic [31:0]      dx_b
);

    localparam logic [4:0] c_OP_RTYPE = 5'b00000;
    localparam logic [4:0] c_OP_J     = 5'b00001;
    localparam logic [4:0] c_OP_BNE   = 5'b00010;
    localparam logic [4:0] c_OP_JAL   = 5'b00011;
    localparam logic [4:0] c_OP_JR    = 5'b00100;
    localparam logic [4:0] c_OP_BLT   = 5'b00110;
    localparam logic [4:0] c_OP_SW    = 5'b00111;
    localparam logic [4:0] c_OP_LW    = 5'b01000;
    localparam logic [4:0] c_OP_SETX  = 5'b10101;
    localparam logic [4:0] c_OP_BEX   = 5'b10110;

    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];

    logic [31:0] dx_insn_q, dx_insn_d;
    logic [31:0] dx_pc_q,   dx_pc_d;
    logic [31:0] dx_a_q,    dx_a_d;
    logic [31:0] dx_b_q,    dx_b_d;

    logic [4:0]  w_opcode, w_rd, w_rs, w_rt;
    logic [4:0]  w_read_a, w_read_b;
    logic        w_uses_a, w_uses_b;
    logic        w_wb_hit;
    logic [31:0] w_port_a, w_port_b;
    logic [4:0]  w_dx_opcode, w_dx_rd;
    logic        w_hazard;

    // Source-field decode of the incoming instruction
    always_comb begin
        w_opcode = insn_in[31:27];
        w_rd     = insn_in[26:22];
        w_rs     = insn_in[21:17];
        w_rt     = insn_in[16:12];

        w_read_a = (w_opcode == c_OP_BEX) ? RSTATUS : w_rs;
        w_read_b = w_rt;
        if (w_opcode == c_OP_SW || w_opcode == c_OP_BNE ||
            w_opcode == c_OP_BLT || w_opcode == c_OP_JR) begin
            w_read_b = w_rd;
        end

        w_uses_a = !(w_opcode == c_OP_J || w_opcode == c_OP_JAL ||
                     w_opcode == c_OP_SETX);
        w_uses_b = (w_opcode == c_OP_RTYPE || w_opcode == c_OP_SW ||
                    w_opcode == c_OP_BNE   || w_opcode == c_OP_BLT ||
                    w_opcode == c_OP_JR);
    end

    // Register file next state; r0 is never written
    always_comb begin
        w_wb_hit = wb.ctrl_writeEnable && (wb.ctrl_writeReg != 5'd0);
        regs_d   = regs_q;
        if (w_wb_hit) begin
            regs_d[wb.ctrl_writeReg] = wb.data_writeReg;
        end
    end

    // Read ports forward a same-cycle writeback so the stage never sees stale data
    always_comb begin
        if (w_read_a == 5'd0) begin
            w_port_a = 32'd0;
        end else if (w_wb_hit && wb.ctrl_writeReg == w_read_a) begin
            w_port_a = wb.data_writeReg;
        end else begin
            w_port_a = regs_q[w_read_a];
        end

        if (w_read_b == 5'd0) begin
            w_port_b = 32'd0;
        end else if (w_wb_hit && wb.ctrl_writeReg == w_read_b) begin
            w_port_b = wb.data_writeReg;
        end else begin
            w_port_b = regs_q[w_read_b];
        end
    end

    always_comb begin
        w_dx_opcode = dx_insn_q[31:27];
        w_dx_rd     = dx_insn_q[26:22];
        w_hazard    = (w_dx_opcode == c_OP_LW) && (w_dx_rd != 5'd0) &&
                      ((w_uses_a && w_read_a == w_dx_rd) ||
                       (w_uses_b && w_read_b == w_dx_rd));
        // A squashed instruction's hazard must not freeze fetch
        stall_out   = w_hazard && !flush;
    end

    always_comb begin
        dx_insn_d = insn_in;
        dx_pc_d   = pc_in;
        dx_a_d    = w_port_a;
        dx_b_d    = w_port_b;
        if (flush || w_hazard) begin
            dx_insn_d = NOP;
            dx_pc_d   = 32'd0;
            dx_a_d    = 32'd0;
            dx_b_d    = 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 32'd0;
            end
            dx_insn_q <= 32'd0;
            dx_pc_q   <= 32'd0;
            dx_a_q    <= 32'd0;
            dx_b_q    <= 32'd0;
        end else begin
            regs_q    <= regs_d;
            dx_insn_q <= dx_insn_d;
            dx_pc_q   <= dx_pc_d;
            dx_a_q    <= dx_a_d;
            dx_b_q    <= dx_b_d;
        end
    end

    assign dx_insn = dx_insn_q;
    assign dx_pc   = dx_pc_q;
    assign dx_a    = dx_a_q;
    assign dx_b    = dx_b_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_read_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_read_regs
// Description : Directed scoreboard bench for the operand-read stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_read_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] insn_in;
    logic [31:0] pc_in;
    logic        flush;
    logic        stall_out;
    logic [31:0] dx_insn, dx_pc, dx_a, dx_b;

    stage_read_regs_if wb ();

    stage_read_regs dut (
        .clock     (clock),
        .reset     (reset),
        .insn_in   (insn_in),
        .pc_in     (pc_in),
        .flush     (flush),
        .wb        (wb),
        .stall_out (stall_out),
        .dx_insn   (dx_insn),
        .dx_pc     (dx_pc),
        .dx_a      (dx_a),
        .dx_b      (dx_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [11:0] low);
        return {op, rd, rs, rt, low};
    endfunction

    // One pipeline cycle: drive at negedge, check stall, push expectation,
    // then pop and compare the D/X latch after the rising edge.
    task automatic step(input string tag, input logic rst, input logic [31:0] insn,
                        input logic [31:0] pc, input logic fl, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd,
                        input logic exp_stall, input logic bubble,
                        input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset               = rst;
        insn_in             = insn;
        pc_in               = pc;
        flush               = fl;
        wb.ctrl_writeEnable = we;
        wb.ctrl_writeReg    = wr;
        wb.data_writeReg    = wd;
        #1;
        chk({tag, ".stall"}, {31'd0, stall_out}, {31'd0, exp_stall});
        e.tag  = tag;
        e.insn = bubble ? 32'd0 : insn;
        e.pc   = bubble ? 32'd0 : pc;
        e.a    = bubble ? 32'd0 : ea;
        e.b    = bubble ? 32'd0 : eb;
        sb.push_back(e);
        @(posedge clock);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk({got.tag, ".dx_insn"}, dx_insn, got.insn);
            chk({got.tag, ".dx_pc"},   dx_pc,   got.pc);
            chk({got.tag, ".dx_a"},    dx_a,    got.a);
            chk({got.tag, ".dx_b"},    dx_b,    got.b);
        end
    endtask

    initial begin
        reset               = 1'b1;
        insn_in             = 32'd0;
        pc_in               = 32'd0;
        flush               = 1'b0;
        wb.ctrl_writeEnable = 1'b0;
        wb.ctrl_writeReg    = 5'd0;
        wb.data_writeReg    = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset.dx_insn", dx_insn, 32'd0);
        chk("reset.dx_pc",   dx_pc,   32'd0);
        chk("reset.dx_a",    dx_a,    32'd0);
        chk("reset.dx_b",    dx_b,    32'd0);
        chk("reset.stall",   {31'd0, stall_out}, 32'd0);

        // Writeback then plain read of the written register
        step("wr_r5",   0, 32'd0,                          32'h00, 0, 1, 5'd5,  32'h1234,     0, 0, 32'd0,        32'd0);
        step("add_r5",  0, mk(5'b00000, 5'd1, 5'd5, 5'd0, 12'd0), 32'h10, 0, 0, 5'd0, 32'd0, 0, 0, 32'h1234,     32'd0);
        // Write-through and r0 immunity
        step("wt_r7",   0, mk(5'b00000, 5'd2, 5'd7, 5'd0, 12'd0), 32'h14, 0, 1, 5'd7, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'd0);
        step("wt_r0",   0, mk(5'b00000, 5'd2, 5'd0, 5'd0, 12'd0), 32'h18, 0, 1, 5'd0, 32'h55,  0, 0, 32'd0,        32'd0);
        // Load-use on port A, with a write to r3 during the bubble
        step("lw_r3a",  0, mk(5'b01000, 5'd3, 5'd2, 5'd0, 12'd0), 32'h20, 0, 0, 5'd0, 32'd0,   0, 0, 32'd0,        32'd0);
        step("lu_a",    0, mk(5'b00000, 5'd4, 5'd3, 5'd2, 12'd0), 32'h24, 0, 1, 5'd3, 32'hAAAA, 1, 1, 32'd0,       32'd0);
        step("lu_a_rp", 0, mk(5'b00000, 5'd4, 5'd3, 5'd2, 12'd0), 32'h24, 0, 0, 5'd0, 32'd0,   0, 0, 32'hAAAA,     32'd0);
        // Load followed by an unrelated addi
        step("lw_r3b",  0, mk(5'b01000, 5'd3, 5'd2, 5'd0, 12'd0), 32'h28, 0, 0, 5'd0, 32'd0,   0, 0, 32'd0,        32'd0);
        step("addi",    0, mk(5'b00101, 5'd4, 5'd2, 5'd0, 12'd5), 32'h2c, 0, 0, 5'd0, 32'd0,   0, 0, 32'd0,        32'd0);
        // Load-use through sw's rd on port B
        step("lw_r3c",  0, mk(5'b01000, 5'd3, 5'd2, 5'd0, 12'd0), 32'h30, 0, 1, 5'd9, 32'h900, 0, 0, 32'd0,        32'd0);
        step("lu_sw",   0, mk(5'b00111, 5'd3, 5'd9, 5'd0, 12'd0), 32'h34, 0, 0, 5'd0, 32'd0,   1, 1, 32'd0,        32'd0);
        step("lu_sw_rp",0, mk(5'b00111, 5'd3, 5'd9, 5'd0, 12'd0), 32'h34, 0, 0, 5'd0, 32'd0,   0, 0, 32'h900,      32'hAAAA);
        // Load to r0 never stalls
        step("lw_r0",   0, mk(5'b01000, 5'd0, 5'd2, 5'd0, 12'd0), 32'h38, 0, 0, 5'd0, 32'd0,   0, 0, 32'd0,        32'd0);
        step("use_r0",  0, mk(5'b00000, 5'd4, 5'd0, 5'd0, 12'd0), 32'h3c, 0, 0, 5'd0, 32'd0,   0, 0, 32'd0,        32'd0);
        // Flush overrides a pending hazard
        step("lw_r3d",  0, mk(5'b01000, 5'd3, 5'd2, 5'd0, 12'd0), 32'h40, 0, 0, 5'd0, 32'd0,   0, 0, 32'd0,        32'd0);
        step("flush",   0, mk(5'b00000, 5'd4, 5'd3, 5'd2, 12'd0), 32'h44, 1, 0, 5'd0, 32'd0,   0, 1, 32'd0,        32'd0);
        // bex reads the status register
        step("wr_r30",  0, 32'd0,                          32'h48, 0, 1, 5'd30, 32'h7,      0, 0, 32'd0,        32'd0);
        step("bex",     0, mk(5'b10110, 5'd0, 5'd0, 5'd0, 12'h40), 32'h4c, 0, 0, 5'd0, 32'd0, 0, 0, 32'h7,        32'd0);
        // Reset wins over a same-cycle writeback
        step("rst_mid", 1, mk(5'b00000, 5'd1, 5'd9, 5'd5, 12'd0), 32'h50, 0, 1, 5'd9, 32'h99, 0, 1, 32'd0,        32'd0);
        step("post_rst",0, mk(5'b00000, 5'd1, 5'd9, 5'd5, 12'd0), 32'h54, 0, 0, 5'd0, 32'd0,  0, 0, 32'd0,        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
